// File: rtl/poly_mul_pkg.sv
// Shared constants and types for the polynomial coefficient multiply/accumulate path.
package poly_mul_pkg;
    localparam int MUL_LAT   = 6;
    localparam int COEF_W    = 64;
    localparam int PROD_W    = 128;
    localparam int RES_SUM_W = 136;
    localparam int RES_CNT_W = 16;

    typedef struct packed {
        logic valid;
        logic last;
    } mac_tag_t;

    typedef struct packed {
        logic [RES_SUM_W-1:0] sum;
        logic [RES_CNT_W-1:0] count;
        logic                 ovf;
    } mac_res_t;
endpackage

// File: rtl/mac_res_fifo.sv
// First-word-fall-through result FIFO with occupancy output; data reads as zero when empty.
module mac_res_fifo #(
    parameter int DW    = 1,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [OW-1:0] occupancy
);
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          do_pop;

    always_comb begin
        do_pop   = pop & (occ_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, do_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= push_data;
    end

    assign out_valid = (occ_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign occupancy = occ_q;
endmodule

// File: rtl/mult_64_mac_issuer.sv
// Issues operand pairs to a fixed-latency 64x64 multiplier and accumulates products per group.
// Optional MAC_OVF_FLAG_EN adds a sticky per-group carry-out flag on out_ovf.
module mult_64_mac_issuer
    import poly_mul_pkg::*;
#(
    parameter int LAT       = MUL_LAT,
    parameter int ACC_W     = 136,
    parameter int CNT_W     = 16,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_a,
    input  logic [COEF_W-1:0] in_b,
    input  logic              in_last,
    output logic [COEF_W-1:0] mul_a,
    output logic [COEF_W-1:0] mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count
`ifdef MAC_OVF_FLAG_EN
    ,
    output logic              out_ovf
`endif
);
`ifdef MAC_OVF_FLAG_EN
    localparam int RES_W = ACC_W + CNT_W + 1;
`else
    localparam int RES_W = ACC_W + CNT_W;
`endif
    localparam int OW = $clog2(RES_DEPTH + 1);

    logic [COEF_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    mac_tag_t          tag_q [0:LAT];
    mac_tag_t          tag_d [0:LAT];
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              ready_en_q, ready_en_d;
    logic              accept, fire, push;
    logic [RES_W-1:0]  push_data, res_data;
    logic [OW-1:0]     occ;
    int                inflight_last;
`ifdef MAC_OVF_FLAG_EN
    logic              ovf_q, ovf_d, carry, ovf_next;
`endif

    always_comb begin
        accept     = in_valid & in_ready;
        ready_en_d = 1'b1;
        mul_a_d    = accept ? in_a : mul_a_q;
        mul_b_d    = accept ? in_b : mul_b_q;
        tag_d[0]   = '{valid: accept, last: accept & in_last};
        for (int i = 1; i <= LAT; i++)
            tag_d[i] = tag_q[i-1];
`ifdef MAC_OVF_FLAG_EN
        {carry, acc_sum} = {1'b0, acc_q} + (ACC_W + 1)'(mul_p);
        ovf_next         = ovf_q | carry;
`else
        acc_sum          = acc_q + ACC_W'(mul_p);
`endif
        cnt_inc = cnt_q + 1'b1;
        fire    = tag_q[LAT].valid;
        push    = fire & tag_q[LAT].last;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef MAC_OVF_FLAG_EN
        ovf_d     = ovf_q;
        push_data = {acc_sum, cnt_inc, ovf_next};
`else
        push_data = {acc_sum, cnt_inc};
`endif
        if (fire) begin
            acc_d = tag_q[LAT].last ? '0 : acc_sum;
            cnt_d = tag_q[LAT].last ? '0 : cnt_inc;
`ifdef MAC_OVF_FLAG_EN
            ovf_d = tag_q[LAT].last ? 1'b0 : ovf_next;
`endif
        end
    end

    // Every last beat still in the tag pipe owns a FIFO slot it will push into.
    always_comb begin
        inflight_last = 0;
        for (int i = 0; i <= LAT; i++)
            inflight_last = inflight_last + int'(tag_q[i].valid & tag_q[i].last);
    end

    assign in_ready = ready_en_q & (~in_last | ((int'(occ) + inflight_last) < RES_DEPTH));
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
            for (int i = 0; i <= LAT; i++)
                tag_q[i] <= '0;
`ifdef MAC_OVF_FLAG_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ready_en_q <= ready_en_d;
            tag_q      <= tag_d;
`ifdef MAC_OVF_FLAG_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    mac_res_fifo #(
        .DW    (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (res_data),
        .occupancy (occ)
    );

`ifdef MAC_OVF_FLAG_EN
    assign {out_sum, out_count, out_ovf} = res_data;
`else
    assign {out_sum, out_count} = res_data;
`endif
endmodule

// File: tb/tb_mult_64_mac_issuer.sv
// Directed and randomised bench for mult_64_mac_issuer with a behavioural 6-stage multiplier.
module tb_mult_64_mac_issuer;
    localparam int LAT = 6;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic         last;
        logic [135:0] exp_sum;
        logic [15:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [135:0] sum;
        logic [15:0]  cnt;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_a = '0;
    logic [63:0]  in_b = '0;
    logic         in_last = 1'b0;
    logic [63:0]  mul_a, mul_b;
    logic [127:0] mul_p;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [135:0] out_sum;
    logic [15:0]  out_count;
`ifdef MAC_OVF_FLAG_EN
    logic         out_ovf;
`endif

    int   n_vec = 0;
    int   n_miss = 0;
    int   n_pop = 0;
    res_t exp_q[$];
    logic [127:0] pipe [0:LAT-1];
    bit   rand_done;

    always #5 clk = ~clk;

    mult_64_mac_issuer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
`ifdef MAC_OVF_FLAG_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    // Behavioural multiplier: product visible LAT edges after the operands change.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {64'b0, mul_a} * {64'b0, mul_b};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_p = pipe[LAT-1];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pop is compared against the next expected result in order.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pop: got sum %0h count %0d expected no result", out_sum, out_count);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                n_pop++;
                $display("pop %0d: sum=%0h count=%0d", n_pop, out_sum, out_count);
                check("pop_sum", 256'(out_sum), 256'(e.sum));
                check("pop_count", 256'(out_count), 256'(e.cnt));
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [0:10];
        logic [63:0]  max64;
        logic [135:0] big;
        max64 = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl[0]  = '{a: 64'd1, b: 64'd2, last: 1'b0, exp_sum: '0, exp_cnt: '0};
        tbl[1]  = '{a: 64'd3, b: 64'd4, last: 1'b0, exp_sum: '0, exp_cnt: '0};
        tbl[2]  = '{a: 64'd5, b: 64'd6, last: 1'b0, exp_sum: '0, exp_cnt: '0};
        tbl[3]  = '{a: 64'd7, b: 64'd8, last: 1'b1, exp_sum: 136'd100, exp_cnt: 16'd4};
        tbl[4]  = '{a: 64'd0, b: 64'd0, last: 1'b1, exp_sum: 136'd0, exp_cnt: 16'd1};
        tbl[5]  = '{a: max64, b: max64, last: 1'b1,
                    exp_sum: {8'h0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001}, exp_cnt: 16'd1};
        tbl[6]  = '{a: 64'd10, b: 64'd10, last: 1'b0, exp_sum: '0, exp_cnt: '0};
        tbl[7]  = '{a: 64'd20, b: 64'd30, last: 1'b1, exp_sum: 136'd700, exp_cnt: 16'd2};
        tbl[8]  = '{a: 64'h8000_0000_0000_0000, b: 64'd4, last: 1'b1,
                    exp_sum: 136'h2_0000_0000_0000_0000, exp_cnt: 16'd1};
        tbl[9]  = '{a: 64'h1_0000_0000, b: 64'h1_0000_0000, last: 1'b0, exp_sum: '0, exp_cnt: '0};
        tbl[10] = '{a: 64'd1, b: 64'd1, last: 1'b1,
                    exp_sum: 136'h1_0000_0000_0000_0001, exp_cnt: 16'd2};

        // Reset state
        in_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 256'(in_ready), 256'd0);
        check("rst_mul_a", 256'(mul_a), 256'd0);
        check("rst_mul_b", 256'(mul_b), 256'd0);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_out_sum", 256'(out_sum), 256'd0);
        check("rst_out_count", 256'(out_count), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_in_ready", 256'(in_ready), 256'd1);
        in_last = 1'b0;

        // Single beat: latency and hold under backpressure
        send(64'd3, 64'd5, 1'b1);
        repeat (LAT) @(posedge clk);
        #1;
        check("lat_valid_early", 256'(out_valid), 256'd0);
        @(posedge clk);
        #1;
        check("lat_valid_on_time", 256'(out_valid), 256'd1);
        check("single_sum", 256'(out_sum), 256'd15);
        check("single_count", 256'(out_count), 256'd1);
        @(posedge clk);
        #1;
        check("hold_sum", 256'(out_sum), 256'd15);
        exp_q.push_back('{sum: 136'd15, cnt: 16'd1});
        out_ready = 1'b1;
        drain();

        // Table-driven groups, back to back
        for (int i = 0; i <= 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].last);
            if (tbl[i].last)
                exp_q.push_back('{sum: tbl[i].exp_sum, cnt: tbl[i].exp_cnt});
        end
        drain();

        // 256 maximal products in one group
        big = 136'd0 - (136'd1 << 73) + 136'd256;
        for (int i = 0; i < 256; i++)
            send(max64, max64, (i == 255));
        exp_q.push_back('{sum: big, cnt: 16'd256});
        drain();

        // Credit backpressure with the consumer stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(64'(k), 64'd1, 1'b1);
            exp_q.push_back('{sum: 136'(k), cnt: 16'd1});
        end
        in_valid = 1'b1;
        in_a     = 64'd5;
        in_b     = 64'd0;
        in_last  = 1'b0;
        @(negedge clk);
        check("bp_nonlast_ready", 256'(in_ready), 256'd1);
        @(posedge clk);
        #1;
        in_b    = 64'd1;
        in_last = 1'b1;
        repeat (20) @(negedge clk);
        check("bp_last_blocked", 256'(in_ready), 256'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_ready_path", 256'(in_ready), 256'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_credit_returned", 256'(in_ready), 256'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.push_back('{sum: 136'd5, cnt: 16'd2});
        out_ready = 1'b1;
        drain();

        // Reset mid-group discards in-flight work
        begin
            int seen;
            send(64'd10, 64'd10, 1'b0);
            send(64'd11, 64'd11, 1'b1);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            seen = 0;
            repeat (15) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("rst_discard", 256'(seen), 256'd0);
            @(posedge clk);
            #1;
            send(64'd2, 64'd3, 1'b1);
            exp_q.push_back('{sum: 136'd6, cnt: 16'd1});
            drain();
        end

        // Random traffic against a reference sum
        rand_done = 1'b0;
        fork
            begin
                for (int g = 0; g < 1000; g++) begin
                    int           n;
                    logic [135:0] s;
                    n = $urandom_range(1, 4);
                    s = '0;
                    for (int j = 0; j < n; j++) begin
                        logic [63:0]  a, b;
                        logic [127:0] p;
                        a = {$urandom, $urandom};
                        b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
                        p = {64'b0, a} * {64'b0, b};
                        s = s + {8'b0, p};
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send(a, b, (j == n - 1));
                    end
                    exp_q.push_back('{sum: s, cnt: 16'(n)});
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mult_64_mac_issuer.md
# mult_64_mac_issuer

Requester-side controller for the fixed-latency 64×64 coefficient multiplier in the polynomial arithmetic path. It accepts a valid/ready stream of operand pairs and drives them into the non-stallable multiplier pipeline one pair per cycle. It tracks each pair with a tag pipeline, collects the 128-bit products when they emerge, and accumulates them into one sum per group, where a group is delimited by IN_LAST. Completed sums leave through a credited result FIFO, so multiplier output is never dropped under output backpressure.

## Interface
- LAT, 6: multiplier latency in clock edges from operand change to product visible on MUL_P.
- ACC_W, 136: accumulator/sum width; must be ≥ 128.
- CNT_W, 16: beat-count width.
- RES_DEPTH, 4: result FIFO entries; must be ≥ 1.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  pair accepted when IN_VALID & IN_READY at a rising edge.
- IN_A, IN_B  in  64 each  coefficients.
- IN_LAST  in  1  final pair of the group.
- MUL_A, MUL_B  out  64 each  registered operands to the multiplier.
- MUL_P  in  128  multiplier product.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  result popped when OUT_VALID & OUT_READY.
- OUT_SUM  out  ACC_W  group sum, mod 2^ACC_W.
- OUT_COUNT  out  CNT_W  beats in the group, mod 2^CNT_W.
- OUT_OVF  out  1  present only with MAC_OVF_FLAG_EN.

## Operation
- Accept edge e0:
  - MUL_A and MUL_B load IN_A and IN_B.
  - The tag pipeline (LAT+1 stages of {valid, last}) loads {1, IN_LAST}.
- Non-accept edge: the operand registers hold their value and the tag stage 0 loads valid=0. Products carrying a valid=0 tag are ignored.
- Tag stage LAT valid at edge e0+LAT+1:
  - acc_next = acc + zero-extend(MUL_P), taken mod 2^ACC_W.
  - cnt_next = cnt + 1.
  - If the tag's last bit is set, push {acc_next, cnt_next} to the FIFO and clear acc and cnt to 0.
- Credits:
  - credit = RES_DEPTH − FIFO occupancy − LAST beats in flight.
  - IN_READY = !IN_LAST | (credit > 0). Non-last beats are never stalled.
- A push can never find the FIFO full; the credit scheme guarantees it.
- Push and pop in the same edge: occupancy is unchanged.
- There are no state-machine states; the block is a pure stream pipeline, fully pipelined at one pair per cycle.

## Timing
- Reset values:
  - IN_READY = 0 while RST_N is low, then 1.
  - MUL_A, MUL_B = 0.
  - OUT_VALID = 0; OUT_SUM, OUT_COUNT = 0; OUT_OVF = 0.
  - acc = 0; all tags invalid; FIFO empty.
- Reset mid-operation discards in-flight tags, the partial group and all FIFO contents.
- FIFO is first-word-fall-through: OUT_VALID rises after the push edge. For a single-beat group accepted at e0, OUT_VALID is high after edge e0+LAT+1.
- OUT_SUM, OUT_COUNT and OUT_OVF hold stable while OUT_VALID & !OUT_READY.
- IN_READY is combinational from IN_LAST and credit; it has no combinational path from OUT_READY.

## Configuration
- MAC_OVF_FLAG_EN defined:
  - A sticky per-group carry bit is set when any accumulate carries out of ACC_W.
  - The bit is stored in the FIFO with the result and presented on OUT_OVF.
- MAC_OVF_FLAG_EN undefined: no OUT_OVF port and no extra storage; sums wrap silently.

## Structure
- Package poly_mul_pkg holds:
  - MUL_LAT = 6, COEF_W = 64, PROD_W = 128.
  - The tag struct {valid, last}.
  - The result struct {sum, count, ovf}.
- Sub-module mac_res_fifo: parameterised RES_DEPTH first-word-fall-through FIFO with occupancy output.
- The multiplier is instantiated by the parent and connected through MUL_A, MUL_B and MUL_P.

## Test plan
- Single beat: A=3, B=5, IN_LAST=1 at e0 → OUT_SUM=15, OUT_COUNT=1, OUT_VALID high after e0+7.
- Group of 4 back-to-back pairs (1×2, 3×4, 5×6, 7×8) → OUT_SUM=100, OUT_COUNT=4, one result only.
- 256 pairs of (2^64−1)×(2^64−1) in one group:
  - With ACC_W=136 → OUT_SUM = 256·(2^64−1)^2 mod 2^136, OUT_COUNT = 256.
  - With MAC_OVF_FLAG_EN and ACC_W=128 → OUT_OVF=1.
- Backpressure with OUT_READY=0: send 5 single-beat groups at RES_DEPTH=4 → IN_READY=0 on the fifth IN_LAST until one pop. Non-last beats are still accepted throughout. No result is lost; results arrive in order 1..5.
- Reset pulse three cycles after accepting a 2-beat group → no OUT_VALID afterwards. The next group's sum excludes the pre-reset products.
- Random valid/ready with 1000 groups vs. a reference model → exact match of sums and counts. FIFO overflow is never asserted.
